// File: rtl/m41_mux.sv
// 4-to-1 multiplexer with a combinational output and a registered shadow copy.
// The shadow side also registers the select and pulses sel_chg when it moves.
module m41_mux #(
   parameter int unsigned           WIDTH     = 1,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [1:0]       S,
   input  logic             en,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_r,
   output logic [1:0]       sel_r,
   output logic             sel_chg
);

   logic [WIDTH-1:0] y_c;
   logic [WIDTH-1:0] y_r_d,     y_r_q;
   logic [1:0]       sel_r_d,   sel_r_q;
   logic             sel_chg_d, sel_chg_q;

   // Data select; an unknown select propagates X rather than holding a value.
   always_comb begin
      y_c = 'x;
      case (S)
         2'b00:   y_c = i0;
         2'b01:   y_c = i1;
         2'b10:   y_c = i2;
         2'b11:   y_c = i3;
         default: y_c = 'x;
      endcase
   end

   always_comb begin
      y_r_d     = y_r_q;
      sel_r_d   = S;
      sel_chg_d = (S != sel_r_q);
      if (en) begin
         y_r_d = y_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_r_q     <= RESET_VAL;
         sel_r_q   <= 2'b00;
         sel_chg_q <= 1'b0;
      end else begin
         y_r_q     <= y_r_d;
         sel_r_q   <= sel_r_d;
         sel_chg_q <= sel_chg_d;
      end
   end

   assign Y       = y_c;
   assign Y_r     = y_r_q;
   assign sel_r   = sel_r_q;
   assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_m41_mux.sv
// Bench for m41_mux: exhaustive 1-bit combinational sweep, directed register
// scenarios, and a randomized 8-bit run scored against a behavioural model.
module tb_m41_mux;

   localparam logic [7:0] RV8 = 8'hA5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // 1-bit instance
   logic       a_rst, a_en;
   logic       a_i0, a_i1, a_i2, a_i3;
   logic [1:0] a_s;
   logic       a_y, a_yr, a_chg;
   logic [1:0] a_selr;

   // 8-bit instance
   logic       b_rst, b_en;
   logic [7:0] b_i0, b_i1, b_i2, b_i3;
   logic [1:0] b_s;
   logic [7:0] b_y, b_yr;
   logic       b_chg;
   logic [1:0] b_selr;

   m41_mux #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(a_rst), .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
      .S(a_s), .en(a_en), .Y(a_y), .Y_r(a_yr), .sel_r(a_selr), .sel_chg(a_chg)
   );

   m41_mux #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
      .clk(clk), .rst(b_rst), .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
      .S(b_s), .en(b_en), .Y(b_y), .Y_r(b_yr), .sel_r(b_selr), .sel_chg(b_chg)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c,
                                       input logic [7:0] d);
      logic [7:0] tbl [4];
      tbl = '{a, b, c, d};
      return tbl[s];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model of the 8-bit instance, advanced on every rising edge.
   logic [7:0] m_yr;
   logic [1:0] m_prev_s;
   logic       m_chg;
   bit         m_valid = 1'b0;

   always @(posedge clk) begin
      if (b_rst) begin
         m_yr     = RV8;
         m_prev_s = 2'b00;
         m_chg    = 1'b0;
         m_valid  = 1'b1;
      end else if (m_valid) begin
         m_chg    = (b_s != m_prev_s);
         m_prev_s = b_s;
         if (b_en) m_yr = pick(b_s, b_i0, b_i1, b_i2, b_i3);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("y8",       b_y,           pick(b_s, b_i0, b_i1, b_i2, b_i3));
         chk("y_r8",     b_yr,          m_yr);
         chk("sel_r8",   8'(b_selr),    8'(m_prev_s));
         chk("sel_chg8", 8'(b_chg),     8'(m_chg));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_rst = 1'b1; a_en = 1'b1; a_s = 2'b00;
      {a_i3, a_i2, a_i1, a_i0} = 4'b0000;
      b_rst = 1'b1; b_en = 1'b1; b_s = 2'b00;
      b_i0 = 8'h00; b_i1 = 8'h00; b_i2 = 8'h00; b_i3 = 8'h00;

      // Clock-independent sweep: i0..i3 toggle every 5/10/20/40, S steps every 80.
      for (int k = 0; k < 64; k++) begin
         logic [5:0] kk;
         kk = 6'(k);
         {a_i3, a_i2, a_i1, a_i0} = kk[3:0];
         a_s = kk[5:4];
         #1;
         chk("comb_y1", 8'(a_y), 8'(kk[32'(a_s)]));
         #4;
      end
      a_s = 2'b10; a_i2 = 1'b1; #1;
      chk("comb_s10_i2_1", 8'(a_y), 8'h01);
      a_i2 = 1'b0; #1;
      chk("comb_s10_i2_0", 8'(a_y), 8'h00);

      // Reset hold with i0=1 selected.
      a_i0 = 1'b1; a_s = 2'b00; a_en = 1'b1; a_rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         step();
         chk("rst_y_r1",     8'(a_yr),   8'h00);
         chk("rst_sel_r1",   8'(a_selr), 8'h00);
         chk("rst_sel_chg1", 8'(a_chg),  8'h00);
         chk("rst_y1",       8'(a_y),    8'h01);
      end
      a_rst = 1'b0;
      step();
      chk("rel_y_r1", 8'(a_yr), 8'h01);

      // Enable hold.
      a_s = 2'b01; a_i1 = 1'b1; a_en = 1'b1;
      step();
      chk("en_cap_y_r1", 8'(a_yr), 8'h01);
      a_en = 1'b0; a_i1 = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("en_hold_y_r1", 8'(a_yr), 8'h01);
         chk("en_hold_y1",   8'(a_y),  8'h00);
      end

      // Select-change pulse.
      a_en = 1'b1; a_s = 2'b00;
      step(); step(); step();
      chk("steady_chg1", 8'(a_chg), 8'h00);
      a_s = 2'b11;
      step();
      chk("chg_pulse1", 8'(a_chg),  8'h01);
      chk("chg_sel_r1", 8'(a_selr), 8'h03);
      step();
      chk("chg_drop1",  8'(a_chg),  8'h00);
      for (int n = 0; n < 4; n++) begin
         a_s = (n % 2 == 0) ? 2'b00 : 2'b11;
         step();
         chk("toggle_chg1", 8'(a_chg), 8'h01);
      end

      // 8-bit walk through all selects.
      b_rst = 1'b0; b_en = 1'b1;
      b_i0 = 8'h11; b_i1 = 8'h22; b_i2 = 8'h44; b_i3 = 8'h88;
      for (int s = 0; s < 4; s++) begin
         logic [7:0] exp_tbl [4];
         exp_tbl = '{8'h11, 8'h22, 8'h44, 8'h88};
         b_s = 2'(s);
         #1;
         chk("walk_y8", b_y, exp_tbl[s]);
         step();
         chk("walk_y_r8", b_yr, exp_tbl[s]);
      end

      // Mid-stream reset pulse.
      b_rst = 1'b1;
      step();
      chk("mid_rst_y_r8", b_yr, 8'hA5);
      b_rst = 1'b0;
      step();
      chk("mid_reload_y_r8", b_yr, 8'h88);

      // Randomized run; the negedge compare process scores every cycle.
      for (int n = 0; n < 400; n++) begin
         b_i0  = 8'($urandom);
         b_i1  = 8'($urandom);
         b_i2  = 8'($urandom);
         b_i3  = 8'($urandom);
         b_s   = 2'($urandom_range(0, 3));
         b_en  = ($urandom_range(0, 3) != 0);
         b_rst = ($urandom_range(0, 15) == 0);
         step();
      end
      b_rst = 1'b0;
      step();
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
